// File: rtl/cdb_arbiter_pkg.sv
// Common-data-bus types shared by the reservation stations, reorder buffer and CDB arbiter.
// Tag 0 means "no producer"; functional unit i produces tag i+1.
package cdb_arbiter_pkg;

   localparam int TAG_W  = 8;
   localparam int DATA_W = 32;
   localparam logic [TAG_W-1:0] TAG_NONE = '0;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] value;
      logic              branch;
   } cdb_t;

   function automatic logic [TAG_W-1:0] idx2tag(input int unsigned idx);
      return TAG_W'(idx + 32'd1);
   endfunction

   function automatic int unsigned tag2idx(input logic [TAG_W-1:0] tag);
      return 32'(tag) - 32'd1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: grants the first requester at or after i_ptr,
// wrapping modulo N. Generic so the issue scheduler can reuse it.
module rr_picker
   import cdb_arbiter_pkg::*;
#(
   parameter int N     = 15,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N) s = s - N;
      return IDX_W'(s);
   endfunction

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!o_valid && i_req[wrap_idx(i_ptr, k)]) begin
            o_valid = 1'b1;
            o_idx   = wrap_idx(i_ptr, k);
         end
      end
      if (o_valid) o_grant[o_idx] = 1'b1;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per functional unit, round-robin grant, and a single
// registered broadcast per cycle with a one-hot release back to the reservation station.
module cdb_arbiter #(
   parameter int N_UNITS = 15,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [N_UNITS-1:0]            fu_valid,
   input  logic [N_UNITS*DATA_W-1:0]     fu_value,
   input  logic [N_UNITS-1:0]            fu_branch,
   output logic [N_UNITS-1:0]            fu_ready,
   output logic                          cdb_valid,
   output logic [TAG_W-1:0]              cdb_tag,
   output logic [DATA_W-1:0]             cdb_value,
   output logic                          cdb_branch,
   output logic [N_UNITS-1:0]            rs_release,
   output logic [$clog2(N_UNITS+1)-1:0]  pending_cnt
);
   import cdb_arbiter_pkg::*;

   localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
   localparam int CNT_W = $clog2(N_UNITS + 1);

   logic [N_UNITS-1:0] r_full;
   logic [DATA_W-1:0]  r_slot_value [N_UNITS];
   logic [N_UNITS-1:0] r_slot_branch;
   logic [IDX_W-1:0]   r_ptr;
   logic [CNT_W-1:0]   r_pending;

   logic               r_cdb_valid_p1;
   logic [TAG_W-1:0]   r_cdb_tag_p1;
   logic [DATA_W-1:0]  r_cdb_value_p1;
   logic               r_cdb_branch_p1;
   logic [N_UNITS-1:0] r_rs_release_p1;

   logic [N_UNITS-1:0] w_grant;
   logic [IDX_W-1:0]   w_gidx;
   logic               w_gvalid;
   logic [N_UNITS-1:0] w_take;
   logic [N_UNITS-1:0] w_full_nxt;

   function automatic logic [CNT_W-1:0] popcount(input logic [N_UNITS-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < N_UNITS; i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
      return (32'(g) == N_UNITS - 1) ? '0 : g + 1'b1;
   endfunction

   rr_picker #(.N(N_UNITS), .IDX_W(IDX_W)) u_picker (
      .i_req   (r_full),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_gidx),
      .o_valid (w_gvalid)
   );

   // A slot can accept while it is being broadcast, so it sustains one result per cycle.
   assign fu_ready   = ~r_full | w_grant | {N_UNITS{flush}};
   assign w_take     = fu_valid & fu_ready;
   assign w_full_nxt = (r_full & ~w_grant) | w_take;

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_UNITS; i++) begin
         if (w_take[i]) begin
            r_slot_value[i]  <= fu_value[i*DATA_W +: DATA_W];
            r_slot_branch[i] <= fu_branch[i];
         end
      end
   end

   // Stage p1: registered CDB broadcast and slot bookkeeping.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_full          <= '0;
         r_pending       <= '0;
         r_cdb_valid_p1  <= 1'b0;
         r_cdb_tag_p1    <= '0;
         r_cdb_value_p1  <= '0;
         r_cdb_branch_p1 <= 1'b0;
         r_rs_release_p1 <= '0;
         if (rst) r_ptr <= '0;
      end else begin
         r_full          <= w_full_nxt;
         r_pending       <= popcount(w_full_nxt);
         r_cdb_valid_p1  <= w_gvalid;
         r_cdb_tag_p1    <= w_gvalid ? TAG_W'(idx2tag(32'(w_gidx))) : '0;
         r_cdb_value_p1  <= w_gvalid ? r_slot_value[w_gidx] : '0;
         r_cdb_branch_p1 <= w_gvalid ? r_slot_branch[w_gidx] : 1'b0;
         r_rs_release_p1 <= w_grant;
         if (w_gvalid) r_ptr <= next_ptr(w_gidx);
      end
   end

   assign cdb_valid   = r_cdb_valid_p1;
   assign cdb_tag     = r_cdb_tag_p1;
   assign cdb_value   = r_cdb_value_p1;
   assign cdb_branch  = r_cdb_branch_p1;
   assign rs_release  = r_rs_release_p1;
   assign pending_cnt = r_pending;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: table of single-unit offers plus hand sequences for contention,
// back-to-back, fairness and flush; broadcasts are matched against an expectation queue.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N  = 15;
   localparam int DW = 32;
   localparam int TW = 8;
   localparam int CW = $clog2(N + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [N-1:0]    fu_valid;
   logic [N*DW-1:0] fu_value;
   logic [N-1:0]    fu_branch;
   logic [N-1:0]    fu_ready;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_value;
   logic            cdb_branch;
   logic [N-1:0]    rs_release;
   logic [CW-1:0]   pending_cnt;

   cdb_arbiter #(.N_UNITS(N), .DATA_W(DW), .TAG_W(TW)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .fu_valid    (fu_valid),
      .fu_value    (fu_value),
      .fu_branch   (fu_branch),
      .fu_ready    (fu_ready),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_value   (cdb_value),
      .cdb_branch  (cdb_branch),
      .rs_release  (rs_release),
      .pending_cnt (pending_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] value;
      logic          branch;
      logic [N-1:0]  rel;
   } exp_t;

   typedef struct {
      int            unit;
      logic [DW-1:0] val;
      logic          br;
      logic [TW-1:0] etag;
      logic [N-1:0]  erel;
   } vec_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   mon_en   = 1'b0;
   int   cyc_cnt  = 0;
   int   tag5_cyc = -1000;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
   endfunction

   function automatic exp_t mk(input logic [TW-1:0] t, input logic [DW-1:0] v,
                               input logic b, input logic [N-1:0] r);
      exp_t e;
      e.tag = t; e.value = v; e.branch = b; e.rel = r;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input int u, input logic [DW-1:0] v, input logic b);
      fu_valid  = fu_valid | (N'(1) << u);
      fu_value[u*DW +: DW] = v;
      fu_branch = (fu_branch & ~(N'(1) << u)) | (N'(b) << u);
   endtask

   task automatic mon_cycle();
      exp_t e;
      if (!mon_en) return;
      if (cdb_valid) begin
         if (cdb_tag == 8'd5) tag5_cyc = cyc_cnt;
         if (exp_q.size() == 0) begin
            chk("bcast_unexpected", 64'(cdb_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("bcast_tag",     64'(cdb_tag),    64'(e.tag));
            chk("bcast_value",   64'(cdb_value),  64'(e.value));
            chk("bcast_branch",  64'(cdb_branch), 64'(e.branch));
            chk("bcast_release", 64'(rs_release), 64'(e.rel));
         end
      end else begin
         chk("idle_outputs", 64'({rs_release, cdb_tag, cdb_branch}), 64'd0);
         chk("idle_value",   64'(cdb_value), 64'd0);
      end
   endtask

   initial forever begin
      @(negedge clk);
      mon_cycle();
   end

   initial begin
      vec_t tbl[5];
      int   cont_pend[4];
      int   v0;
      bit   acc;
      int   start_cyc;

      tbl[0] = '{3,  32'd42,         1'b0, 8'd4,  15'h0008};
      tbl[1] = '{0,  32'd7,          1'b1, 8'd1,  15'h0001};
      tbl[2] = '{9,  32'hDEADBEEF,   1'b1, 8'd10, 15'h0200};
      tbl[3] = '{7,  32'd1234,       1'b0, 8'd8,  15'h0080};
      tbl[4] = '{14, 32'hFFFF_FFFF,  1'b1, 8'd15, 15'h4000};
      cont_pend = '{3, 2, 1, 0};

      // Reset held for two edges with random offers.
      rst = 1'b1; flush = 1'b0;
      fu_value = '0; fu_branch = '0;
      fu_valid = N'($urandom);
      repeat (2) begin
         step();
         fu_valid = N'($urandom);
      end
      rst = 1'b0;
      fu_valid = '0;
      @(negedge clk);
      chk("rst_cdb_valid", 64'(cdb_valid),   64'd0);
      chk("rst_cdb_tag",   64'(cdb_tag),     64'd0);
      chk("rst_ready",     64'(fu_ready),    64'h7FFF);
      chk("rst_pending",   64'(pending_cnt), 64'd0);
      chk("rst_release",   64'(rs_release),  64'd0);
      mon_en = 1'b1;
      step();

      // Single offers: two-cycle latency, one-cycle pulse.
      foreach (tbl[v]) begin
         offer(tbl[v].unit, tbl[v].val, tbl[v].br);
         chk("single_ready", 64'((fu_ready >> tbl[v].unit) & N'(1)), 64'd1);
         exp_q.push_back(mk(tbl[v].etag, tbl[v].val, tbl[v].br, tbl[v].erel));
         step();
         fu_valid = '0;
         @(negedge clk);
         chk("single_pend_t1",  64'(pending_cnt), 64'd1);
         chk("single_valid_t1", 64'(cdb_valid),   64'd0);
         step();
         @(negedge clk);
         chk("single_valid_t2", 64'(cdb_valid),   64'd1);
         step();
         @(negedge clk);
         chk("single_valid_t3", 64'(cdb_valid),   64'd0);
         chk("single_pend_t3",  64'(pending_cnt), 64'd0);
         step();
      end

      // Contention with ptr back at 0 after unit 14's grant.
      offer(0, 32'd10, 1'b0); offer(1, 32'd20, 1'b0); offer(2, 32'd30, 1'b0);
      exp_q.push_back(mk(8'd1, 32'd10, 1'b0, 15'h0001));
      exp_q.push_back(mk(8'd2, 32'd20, 1'b0, 15'h0002));
      exp_q.push_back(mk(8'd3, 32'd30, 1'b0, 15'h0004));
      step();
      fu_valid = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("cont_pending", 64'(pending_cnt), 64'(cont_pend[k]));
         chk("cont_valid",   64'(cdb_valid),   64'(k > 0));
         step();
      end
      repeat (2) step();

      // Back-to-back on the Beq slot.
      offer(7, 32'd10, 1'b1);
      chk("b2b_ready0", 64'(fu_ready[7]), 64'd1);
      exp_q.push_back(mk(8'd8, 32'd10, 1'b1, 15'h0080));
      step();
      offer(7, 32'd11, 1'b0);
      chk("b2b_ready1", 64'(fu_ready[7]), 64'd1);
      exp_q.push_back(mk(8'd8, 32'd11, 1'b0, 15'h0080));
      step();
      fu_valid = '0;
      @(negedge clk);
      chk("b2b_valid_t2", 64'(cdb_valid), 64'd1);
      step();
      @(negedge clk);
      chk("b2b_valid_t3", 64'(cdb_valid), 64'd1);
      step();
      @(negedge clk);
      chk("b2b_valid_t4", 64'(cdb_valid), 64'd0);
      step();

      // Fairness: unit 0 always offering, unit 4 offers once.
      v0 = 100;
      start_cyc = cyc_cnt;
      for (int k = 0; k < 8; k++) begin
         offer(0, DW'(v0), 1'b0);
         if (k == 0) offer(4, 32'd99, 1'b0);
         acc = fu_ready[0];
         if (acc) exp_q.push_back(mk(8'd1, DW'(v0), 1'b0, 15'h0001));
         if (k == 0) exp_q.push_back(mk(8'd5, 32'd99, 1'b0, 15'h0010));
         step();
         if (acc) v0++;
         fu_valid = fu_valid & ~(N'(1) << 4);
      end
      fu_valid = '0;
      repeat (20) step();
      chk("fair_tag5_seen", 64'((tag5_cyc - start_cyc) >= 2 && (tag5_cyc - start_cyc) <= 15), 64'd1);
      chk("fair_unit0_accepted", 64'(v0), 64'd107);
      chk("fair_drained", 64'(exp_q.size()), 64'd0);

      // Flush with three slots full and one broadcast registered.
      offer(5, 32'd50, 1'b0); offer(6, 32'd60, 1'b1); offer(9, 32'd90, 1'b0); offer(10, 32'd100, 1'b1);
      exp_q.push_back(mk(8'd6, 32'd50, 1'b0, 15'h0020));
      step();
      fu_valid = '0;
      @(negedge clk);
      chk("flush_pend_pre", 64'(pending_cnt), 64'd4);
      step();
      flush = 1'b1;
      offer(2, 32'd77, 1'b1);
      @(negedge clk);
      chk("flush_ready",    64'(fu_ready),    64'h7FFF);
      chk("flush_pend_in",  64'(pending_cnt), 64'd3);
      chk("flush_valid_in", 64'(cdb_valid),   64'd1);
      step();
      flush = 1'b0;
      fu_valid = '0;
      @(negedge clk);
      chk("flush_valid_after", 64'(cdb_valid),   64'd0);
      chk("flush_pend_after",  64'(pending_cnt), 64'd0);
      repeat (20) step();
      chk("flush_quiet", 64'(exp_q.size()), 64'd0);

      // Recovery after flush.
      offer(2, 32'd55, 1'b0);
      exp_q.push_back(mk(8'd3, 32'd55, 1'b0, 15'h0004));
      step();
      fu_valid = '0;
      repeat (4) step();
      chk("recover_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
